soc_interconnect: RTL and testbench
===================================

# soc_interconnect

Parametrised multi-host, multi-device interconnect for the SoC: the successor to the single-host `bus`, connecting N cores/DMA masters to M memory-mapped devices (RAM, console, CLINT, ...). Devices are decoded with runtime base/mask pairs. Hosts are served one transaction per cycle with fair round-robin arbitration. Every granted access gets a registered one-cycle response carrying read data and an error flag.

## Interface
Parameters:
- NR_HOSTS, 2, number of host ports (≥1)
- NR_DEVICES, 3, number of device ports (≥1)
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width

Ports (arrays flattened, index k at bits [k*W +: W]):
- clk_i  in  1  single clock; all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- host_req_i  in  NR_HOSTS  access request per host
- host_gnt_o  out  NR_HOSTS  one-hot grant, combinational
- host_addr_i  in  NR_HOSTS*ADDR_WIDTH  byte address
- host_we_i  in  NR_HOSTS  1 = write, 0 = read
- host_wdata_i  in  NR_HOSTS*DATA_WIDTH  write data
- host_rvalid_o  out  NR_HOSTS  response strobe, registered
- host_rdata_o  out  NR_HOSTS*DATA_WIDTH  read data, valid with rvalid
- host_err_o  out  NR_HOSTS  error flag, valid with rvalid
- device_req_o  out  NR_DEVICES  one-hot device select
- device_addr_o  out  ADDR_WIDTH  shared address to devices
- device_we_o  out  1  shared write enable
- device_wdata_o  out  DATA_WIDTH  shared write data
- device_rdata_i  in  NR_DEVICES*DATA_WIDTH  device read data, valid one cycle after req
- cfg_device_addr_base_i  in  NR_DEVICES*ADDR_WIDTH  device base addresses
- cfg_device_addr_mask_i  in  NR_DEVICES*ADDR_WIDTH  device address masks

## Operation
- Arbitration: round-robin pointer `rr_ptr` (clog2(NR_HOSTS) bits). The granted host is the first requester at or after `rr_ptr`, wrapping modulo NR_HOSTS.
- `rr_ptr` updates only on a grant, to granted index + 1 mod NR_HOSTS. It holds when there are no requests. With NR_HOSTS=1 the pointer is constant 0.
- Decode of the granted address: device d matches when (addr & mask_d) == base_d. With multiple matches, the lowest d wins.
- device_addr_o, device_we_o and device_wdata_o are driven from the granted host. They are 0 when no host is granted.
- device_req_o is one-hot for the matched device and 0 when no grant or no match.
- Response register, loaded every cycle: `rsp_valid` (grant seen), `rsp_host`, `rsp_dev`, `rsp_err` (unmapped).
- host_rvalid_o[rsp_host] = rsp_valid. This applies to both reads and writes; writes get rdata = 0.
- host_rdata_o[rsp_host] = device_rdata_i[rsp_dev] for a mapped read. Every other host's rdata is 0.
- Unmapped access: no device strobe. A response still occurs with err = 1 and rdata = 0 (see Configuration).

## Timing
- Cycle T: host_req_i and host_gnt_o are high in the same cycle, and device_req_o fires combinationally in T.
- Cycle T+1: host_rvalid_o pulses for exactly one cycle. Fixed latency is 1 for every access.
- Back-to-back accesses: a host may re-request in T+1 and be granted. Throughput is 1 transaction/cycle aggregate.
- A host holding req without gnt waits. Requests carry no ordering obligation. A host may drop req before it is granted.
- Simultaneous requests from all hosts: the grant rotates, and each host is served within NR_HOSTS cycles.
- Reset values: rr_ptr = 0, rsp_valid = 0, rsp_err = 0. All host_rvalid_o, host_err_o and host_rdata_o are 0. Outputs are 0 for the whole reset cycle: with rst_i high, host_gnt_o and device_req_o are forced to 0.
- Reset mid-operation: a response pending for T+1 is dropped (no rvalid), and no device is strobed in the reset cycle.
- cfg base/mask are sampled combinationally. Changing them affects only new grants.

## Configuration
- `SOC_IC_ERR_RESP_EN` defined: unmapped addresses return host_err_o = 1, rdata = 0, and no device strobe.
- Undefined: unmapped addresses route to device 0 as default slave. device_req_o[0] is asserted, and the response carries device 0 rdata with host_err_o tied to 0.

## Test plan
- Single host read: NR_HOSTS=2, host0 reads 0x0000_0010 mapped to RAM (base 0, mask ~0x1FFFFF) → gnt0 and device_req[0] in T; rvalid0 in T+1 with RAM data 0xDEADBEEF, err 0; host1 rdata = 0.
- Round-robin: both hosts request continuously for 6 cycles → grants 0,1,0,1,0,1; each response lands on the matching host one cycle later.
- Decode priority: devices 1 and 2 both match 0x0200_0000 → only device_req[1] asserted.
- Unmapped write to 0xF000_0000 with `SOC_IC_ERR_RESP_EN` → no device_req; rvalid + err=1 in T+1. Without the macro → device_req[0]=1, err=0.
- Reset mid-operation: grant in T, rst_i high in T+1 → no rvalid in T+1; rr_ptr = 0 and all outputs 0 afterwards; next simultaneous request is granted to host 0.

Source files
------------

// File: rtl/soc_interconnect.sv
// soc_interconnect: round-robin multi-host to multi-device interconnect with base/mask decode and a registered 1-cycle response.
// Optional macro SOC_IC_ERR_RESP_EN: unmapped accesses return an error instead of being routed to device 0.
module soc_interconnect #(
  parameter int NR_HOSTS   = 2,
  parameter int NR_DEVICES = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_HOSTS-1:0]              host_req_i,
  output logic [NR_HOSTS-1:0]              host_gnt_o,
  input  logic [NR_HOSTS*ADDR_WIDTH-1:0]   host_addr_i,
  input  logic [NR_HOSTS-1:0]              host_we_i,
  input  logic [NR_HOSTS*DATA_WIDTH-1:0]   host_wdata_i,
  output logic [NR_HOSTS-1:0]              host_rvalid_o,
  output logic [NR_HOSTS*DATA_WIDTH-1:0]   host_rdata_o,
  output logic [NR_HOSTS-1:0]              host_err_o,
  output logic [NR_DEVICES-1:0]            device_req_o,
  output logic [ADDR_WIDTH-1:0]            device_addr_o,
  output logic                             device_we_o,
  output logic [DATA_WIDTH-1:0]            device_wdata_o,
  input  logic [NR_DEVICES*DATA_WIDTH-1:0] device_rdata_i,
  input  logic [NR_DEVICES*ADDR_WIDTH-1:0] cfg_device_addr_base_i,
  input  logic [NR_DEVICES*ADDR_WIDTH-1:0] cfg_device_addr_mask_i
);

  localparam int HOST_W = (NR_HOSTS > 1) ? $clog2(NR_HOSTS) : 1;
  localparam int DEV_W  = (NR_DEVICES > 1) ? $clog2(NR_DEVICES) : 1;
  localparam logic [HOST_W-1:0] LAST_HOST = HOST_W'(NR_HOSTS - 1);

  logic [HOST_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [HOST_W-1:0]     rsp_host_q, rsp_host_d;
  logic [DEV_W-1:0]      rsp_dev_q, rsp_dev_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_we_q, rsp_we_d;

  logic                  gnt_valid;
  logic [HOST_W-1:0]     gnt_idx;
  logic [HOST_W-1:0]     cand;
  int                    cand_sum;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic                  gnt_we;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic                  dev_hit;
  logic [DEV_W-1:0]      dev_idx;
  logic                  route_hit;
  logic [DEV_W-1:0]      route_idx;
  logic                  route_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  // Scan hosts starting at rr_ptr and wrapping; the first requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand_sum  = 0;
    cand      = '0;
    for (int i = 0; i < NR_HOSTS; i++) begin
      cand_sum = int'(rr_ptr_q) + i;
      if (cand_sum >= NR_HOSTS) cand_sum = cand_sum - NR_HOSTS;
      cand = HOST_W'(cand_sum);
      if (!gnt_valid && host_req_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (rst_i) gnt_valid = 1'b0;
  end

  always_comb begin
    host_gnt_o = '0;
    gnt_addr   = '0;
    gnt_we     = 1'b0;
    gnt_wdata  = '0;
    if (gnt_valid) begin
      host_gnt_o[gnt_idx] = 1'b1;
      gnt_addr  = host_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      gnt_we    = host_we_i[gnt_idx];
      gnt_wdata = host_wdata_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Walk devices from the top down so the lowest matching index is the one left standing.
  always_comb begin
    dev_hit = 1'b0;
    dev_idx = '0;
    for (int d = NR_DEVICES - 1; d >= 0; d--) begin
      if ((gnt_addr & cfg_device_addr_mask_i[d*ADDR_WIDTH +: ADDR_WIDTH]) ==
          cfg_device_addr_base_i[d*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dev_hit = 1'b1;
        dev_idx = DEV_W'(d);
      end
    end
  end

`ifdef SOC_IC_ERR_RESP_EN
  assign route_hit = dev_hit;
  assign route_idx = dev_idx;
  assign route_err = !dev_hit;
`else
  assign route_hit = 1'b1;
  assign route_idx = dev_hit ? dev_idx : '0;
  assign route_err = 1'b0;
`endif

  always_comb begin
    device_req_o = '0;
    if (gnt_valid && route_hit) device_req_o[route_idx] = 1'b1;
  end

  assign device_addr_o  = gnt_addr;
  assign device_we_o    = gnt_we;
  assign device_wdata_o = gnt_wdata;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) rr_ptr_d = (gnt_idx == LAST_HOST) ? '0 : gnt_idx + HOST_W'(1);
    rsp_valid_d = gnt_valid;
    rsp_host_d  = gnt_idx;
    rsp_dev_d   = route_idx;
    rsp_err_d   = gnt_valid & route_err;
    rsp_we_d    = gnt_valid & gnt_we;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_host_q  <= '0;
      rsp_dev_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_host_q  <= rsp_host_d;
      rsp_dev_q   <= rsp_dev_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  // Device read data arrives the cycle after the strobe, so it is muxed straight from the input.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    rsp_rdata     = device_rdata_i[int'(rsp_dev_q)*DATA_WIDTH +: DATA_WIDTH];
    if (rsp_valid_q && !rst_i) begin
      host_rvalid_o[rsp_host_q] = 1'b1;
      host_err_o[rsp_host_q]    = rsp_err_q;
      if (!rsp_we_q && !rsp_err_q)
        host_rdata_o[int'(rsp_host_q)*DATA_WIDTH +: DATA_WIDTH] = rsp_rdata;
    end
  end

endmodule

// File: tb/tb_soc_interconnect.sv
// Randomized scoreboard bench for soc_interconnect; the reference model follows the SOC_IC_ERR_RESP_EN macro like the DUT.
module tb_soc_interconnect;

   localparam int NH = 2;
   localparam int ND = 3;
   localparam int DW = 32;
   localparam int AW = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NH-1:0]    hostReq = '0;
   logic [NH-1:0]    hostGnt;
   logic [NH*AW-1:0] hostAddr = '0;
   logic [NH-1:0]    hostWe = '0;
   logic [NH*DW-1:0] hostWdata = '0;
   logic [NH-1:0]    hostRvalid;
   logic [NH*DW-1:0] hostRdata;
   logic [NH-1:0]    hostErr;
   logic [ND-1:0]    devReq;
   logic [AW-1:0]    devAddr;
   logic             devWe;
   logic [DW-1:0]    devWdata;
   logic [ND*DW-1:0] devRdata = '0;
   logic [ND*AW-1:0] cfgBase;
   logic [ND*AW-1:0] cfgMask;

   typedef struct {
      int          cyc;
      int          host;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   rsp_t          expQ[$];
   int            errors = 0;
   int            checks = 0;
   int            cycCount = 0;
   int            modelPtr = 0;
   logic [AW-1:0] devBase[ND];
   logic [AW-1:0] devMask[ND];
   logic [ND-1:0] seenReq = '0;
   logic [AW-1:0] seenAddr = '0;
   logic [NH-1:0] expGnt;
   logic [ND-1:0] expDevReq;
   logic [AW-1:0] expAddr;
   logic          expWe;
   logic [DW-1:0] expWdata;

   soc_interconnect #(
      .NR_HOSTS(NH), .NR_DEVICES(ND), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .host_req_i(hostReq),
      .host_gnt_o(hostGnt),
      .host_addr_i(hostAddr),
      .host_we_i(hostWe),
      .host_wdata_i(hostWdata),
      .host_rvalid_o(hostRvalid),
      .host_rdata_o(hostRdata),
      .host_err_o(hostErr),
      .device_req_o(devReq),
      .device_addr_o(devAddr),
      .device_we_o(devWe),
      .device_wdata_o(devWdata),
      .device_rdata_i(devRdata),
      .cfg_device_addr_base_i(cfgBase),
      .cfg_device_addr_mask_i(cfgMask)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Cycle counter used to timestamp when each response is due.
   always @(posedge clk) cycCount <= cycCount + 1;

   // Each device answers with data derived from its index and the address it saw.
   function automatic logic [31:0] devData(input int d, input logic [31:0] a);
      return {8'(d + 1), a[23:0]} ^ 32'h5A5A_0000;
   endfunction

   // Pick addresses from each decode region so every routing case gets exercised.
   function automatic logic [31:0] randAddr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 4))
         0:       return {11'b0, r[20:0]};
         1:       return 32'h0200_0000 | {16'b0, r[15:0]};
         2:       return {8'h02, 8'($urandom_range(1, 255)), r[15:0]};
         3:       return {4'hF, r[27:0]};
         default: return r;
      endcase
   endfunction

   task automatic reportFail(input string name, input string detail);
      checks++;
      errors++;
      $display("[TB] FAIL %s: %s at cycle %0d", name, detail, cycCount);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h required %h at cycle %0d", name, act, req, cycCount);
      end
   endtask

   // Compare the combinational grant/device side against the model and remember the strobe for the device model.
   task automatic checkOutput();
      check("host_gnt", 64'(hostGnt), 64'(expGnt));
      check("device_req", 64'(devReq), 64'(expDevReq));
      check("device_addr", 64'(devAddr), 64'(expAddr));
      check("device_we", 64'(devWe), 64'(expWe));
      check("device_wdata", 64'(devWdata), 64'(expWdata));
      seenReq  = devReq;
      seenAddr = devAddr;
   endtask

   // Drive one cycle of stimulus, run the reference model, queue the expected response, then check at negedge.
   task automatic applyStimulus(input logic [NH-1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [NH-1:0] we, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                input logic r);
      int   host;
      int   h;
      int   dev;
      int   rdev;
      logic err;
      @(posedge clk);
      #1;
      rst       = r;
      hostReq   = req;
      hostAddr  = {a1, a0};
      hostWe    = we;
      hostWdata = {w1, w0};
      for (int d = 0; d < ND; d++)
         devRdata[d*DW +: DW] = seenReq[d] ? devData(d, seenAddr) : $urandom;
      if (r) expQ.delete();
      expGnt = '0; expDevReq = '0; expAddr = '0; expWe = 1'b0; expWdata = '0;
      host = -1;
      if (!r) begin
         for (int k = 0; k < NH; k++) begin
            h = (modelPtr + k) % NH;
            if (host < 0 && req[h]) host = h;
         end
      end
      if (r) modelPtr = 0;
      else if (host >= 0) begin
         modelPtr = (host + 1) % NH;
         expGnt[host] = 1'b1;
         expAddr  = (host == 1) ? a1 : a0;
         expWe    = we[host];
         expWdata = (host == 1) ? w1 : w0;
         dev = -1;
         for (int d = 0; d < ND; d++)
            if (dev < 0 && ((expAddr & devMask[d]) == devBase[d])) dev = d;
`ifdef SOC_IC_ERR_RESP_EN
         err  = (dev < 0);
         rdev = dev;
`else
         err  = 1'b0;
         rdev = (dev < 0) ? 0 : dev;
`endif
         if (rdev >= 0) expDevReq[rdev] = 1'b1;
         expQ.push_back('{cyc: cycCount + 1, host: host, err: err,
                          rdata: (expWe || err) ? 32'h0 : devData(rdev, expAddr)});
      end
      @(negedge clk);
      checkOutput();
   endtask

   // Monitor: pop the scoreboard whenever a response strobe appears and verify idle hosts stay quiet.
   always @(negedge clk) begin
      rsp_t item;
      int   nValid;
      nValid = 0;
      while (expQ.size() > 0 && expQ[0].cyc < cycCount) begin
         item = expQ.pop_front();
         reportFail("rvalid_missing", $sformatf("no response for host %0d", item.host));
      end
      for (int hh = 0; hh < NH; hh++) if (hostRvalid[hh]) nValid++;
      check("rvalid_count_le1", 64'(nValid <= 1), 64'd1);
      for (int hh = 0; hh < NH; hh++) begin
         if (hostRvalid[hh]) begin
            if (expQ.size() == 0 || expQ[0].cyc != cycCount)
               reportFail("rvalid_unexpected", $sformatf("host %0d strobed with nothing due", hh));
            else begin
               item = expQ.pop_front();
               check("rsp_host", 64'(hh), 64'(item.host));
               check("rsp_err", 64'(hostErr[hh]), 64'(item.err));
               check("rsp_rdata", 64'(hostRdata[hh*DW +: DW]), 64'(item.rdata));
            end
         end else begin
            check("idle_rdata", 64'(hostRdata[hh*DW +: DW]), 64'd0);
            check("idle_err", 64'(hostErr[hh]), 64'd0);
         end
      end
   end

   // Main sequence: reset, the directed scenarios, a long random run, then drain and summarize.
   initial begin
      devBase[0] = 32'h0000_0000; devMask[0] = 32'hFFE0_0000;
      devBase[1] = 32'h0200_0000; devMask[1] = 32'hFFFF_0000;
      devBase[2] = 32'h0200_0000; devMask[2] = 32'hFF00_0000;
      for (int d = 0; d < ND; d++) begin
         cfgBase[d*AW +: AW] = devBase[d];
         cfgMask[d*AW +: AW] = devMask[d];
      end
      $display("[TB] reset with both hosts requesting");
      applyStimulus(2'b11, 32'h10, 32'h20, 2'b00, 0, 0, 1'b1);
      applyStimulus(2'b11, 32'h10, 32'h20, 2'b00, 0, 0, 1'b1);
      $display("[TB] single host read");
      applyStimulus(2'b01, 32'h0000_0010, 32'h0, 2'b00, 0, 0, 1'b0);
      applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 1'b0);
      $display("[TB] round-robin with both hosts requesting");
      for (int i = 0; i < 6; i++)
         applyStimulus(2'b11, randAddr(), randAddr(), 2'($urandom), $urandom, $urandom, 1'b0);
      $display("[TB] decode priority and unmapped write");
      applyStimulus(2'b10, 32'h0, 32'h0200_0000, 2'b00, 0, 0, 1'b0);
      applyStimulus(2'b01, 32'hF000_0000, 32'h0, 2'b01, 32'hCAFE_F00D, 0, 1'b0);
      applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 1'b0);
      $display("[TB] reset mid-operation");
      applyStimulus(2'b01, 32'h0000_0100, 32'h0, 2'b00, 0, 0, 1'b0);
      applyStimulus(2'b11, 32'h0000_0200, 32'h0200_0004, 2'b00, 0, 0, 1'b1);
      applyStimulus(2'b11, 32'h0000_0300, 32'h0200_0008, 2'b00, 0, 0, 1'b0);
      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++)
         applyStimulus(2'($urandom), randAddr(), randAddr(), 2'($urandom), $urandom, $urandom,
                       ($urandom_range(0, 39) == 0));
      for (int i = 0; i < 3; i++)
         applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 0, 0, 1'b0);
      check("queue_drained", 64'(expQ.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
